// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I integer ALU with registered result and zero flag.
//
// Decodes the raw RISC-V control fields (ALUOp, funct3, funct7b5, opb5) and
// executes the base integer ALU ops in one cycle. When the ALU_MEXT_EN macro
// is defined, the M-extension ops (ALUOp=10, opb5=1, funct7b0=1) are also
// executed. They use an iterative shift-add multiplier or a restoring divider
// that processes one bit per cycle over operand magnitudes, with a sign
// fixup applied at the end. Without ALU_MEXT_EN, funct7b0 is ignored.
//
// Ports:
//   clk, rst_n            core clock (rising edge), async active-low reset
//   in_valid / in_ready   request handshake; fields sampled on accept only
//   ALUOp, funct3,        decode fields (funct7b5 = instr[30],
//   funct7b5, funct7b0,   funct7b0 = instr[25], opb5 = op[5])
//   opb5
//   src_a, src_b          XLEN-bit operands
//   out_valid / out_ready result handshake
//   result, zero          registered result and (result == 0)
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            opb5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

`ifdef ALU_MEXT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            accept;
    logic [XLEN-1:0] base_res;
    logic [SHW-1:0]  shamt;

    assign shamt     = src_b[SHW-1:0];
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // Single-cycle base ALU, decoded straight from the request fields.
    always_comb begin
        base_res = src_a + src_b;
        if (ALUOp == 2'b01) begin
            base_res = src_a - src_b;
        end else if (ALUOp == 2'b10) begin
            case (funct3)
                3'b000:  base_res = (funct7b5 && opb5) ? src_a - src_b : src_a + src_b;
                3'b001:  base_res = src_a << shamt;
                3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                3'b011:  base_res = {{(XLEN-1){1'b0}}, src_a < src_b};
                3'b100:  base_res = src_a ^ src_b;
                3'b101:  base_res = funct7b5 ? $unsigned($signed(src_a) >>> shamt)
                                             : src_a >> shamt;
                3'b110:  base_res = src_a | src_b;
                default: base_res = src_a & src_b;
            endcase
        end
    end

`ifdef ALU_MEXT_EN
    logic [SHW-1:0]    cnt_q, cnt_d;
    // hi/lo form the double-width accumulator: {partial product, multiplier}
    // for multiply, {partial remainder, dividend/quotient} for divide.
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]   opd_q, opd_d;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   a_q, a_d;          // raw src_a for the divide special cases
    logic [2:0]        mop_q, mop_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
    logic              is_mop, a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   hi_n, lo_n, quo, rem, m_res;
    logic [2*XLEN-1:0] prod, prod_s;

    assign is_mop   = (ALUOp == 2'b10) && opb5 && funct7b0;
    assign a_signed = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    assign b_signed = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    assign sign_a   = a_signed && src_a[XLEN-1];
    assign sign_b   = b_signed && src_b[XLEN-1];
    assign a_mag    = sign_a ? ('0 - src_a) : src_a;
    assign b_mag    = sign_b ? ('0 - src_b) : src_b;

    // One iteration of the multiply/divide step, plus the final sign fixup
    // applied to the post-iteration values so the last step lands in DONE.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opd_q};
        if (mop_q[2]) begin
            // Restoring step: keep the shifted remainder if the trial subtract borrows.
            hi_n = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = neg_q ? ('0 - prod) : prod;
        quo    = neg_q ? ('0 - lo_n) : lo_n;
        rem    = rneg_q ? ('0 - hi_n) : hi_n;
        if (dz_q) begin
            quo = '1;
            rem = a_q;
        end else if (ovf_q) begin
            quo = a_q;
            rem = '0;
        end
        case (mop_q)
            3'b000:                 m_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_res = quo;
            default:                m_res = rem;
        endcase
    end
`else
    logic unused_funct7b0;
    assign unused_funct7b0 = funct7b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_MEXT_EN
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opd_d  = opd_q;
        a_d    = a_q;
        mop_d  = mop_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
`ifdef ALU_MEXT_EN
                    if (is_mop) begin
                        state_d = CALC;
                        cnt_d   = SHW'(XLEN - 1);
                        hi_d    = '0;
                        lo_d    = funct3[2] ? a_mag : b_mag;
                        opd_d   = funct3[2] ? b_mag : a_mag;
                        a_d     = src_a;
                        mop_d   = funct3;
                        neg_d   = sign_a ^ sign_b;
                        rneg_d  = sign_a;
                        dz_d    = funct3[2] && (src_b == '0);
                        ovf_d   = funct3[2] && !funct3[0] && (src_b == '1)
                                  && (src_a == {1'b1, {(XLEN-1){1'b0}}});
                    end else
`endif
                    begin
                        state_d  = DONE;
                        result_d = base_res;
                        zero_d   = (base_res == '0);
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_MEXT_EN
            CALC: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = m_res;
                    zero_d   = (m_res == '0);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_MEXT_EN
            // NOTE: the iterative accumulators are reset too, so an op aborted by reset leaves no residue.
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            a_q    <= '0;
            mop_q  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_MEXT_EN
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opd_q  <= opd_d;
            a_q    <= a_d;
            mop_q  <= mop_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (XLEN=32). A behavioural reference model
// computes every expected value with plain integer arithmetic. M-extension
// scenarios are included when ALU_MEXT_EN is defined.
module tb_alu_seq;

    localparam int XLEN = 32;
`ifdef ALU_MEXT_EN
    localparam bit MEXT_ON = 1'b1;
`else
    localparam bit MEXT_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            funct7b0;
    logic            opb5;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .opb5     (opb5),
        .src_a    (src_a),
        .src_b    (src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, ub, p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7b5, input logic f7b0,
                                            input logic ob5, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int          s;
        s = int'(b[4:0]);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        if (MEXT_ON && ob5 && f7b0) return ref_m(f3, a, b);
        case (f3)
            3'd0: return (f7b5 && ob5) ? a - b : a + b;
            3'd1: return a << s;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                r = a >> s;
                if (f7b5 && a[31]) r = r | ~(32'hFFFF_FFFF >> s);
                return r;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic scramble();
        ALUOp    = 2'($urandom);
        funct3   = 3'($urandom);
        funct7b5 = 1'($urandom);
        funct7b0 = 1'($urandom);
        opb5     = 1'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic gen_base_op(output logic [1:0] op, output logic [2:0] f3,
                               output logic f7b5, output logic f7b0, output logic ob5,
                               output logic [31:0] a, output logic [31:0] b);
        op   = 2'($urandom);
        f3   = 3'($urandom);
        f7b5 = 1'($urandom);
        ob5  = 1'($urandom);
        f7b0 = 1'($urandom);
        if (MEXT_ON && op == 2'b10 && ob5) f7b0 = 1'b0;
        a = $urandom;
        b = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
        if ($urandom_range(7) == 0) b = a;
    endtask

    // Performs one full transaction with out_ready held high; returns the
    // result, zero flag and the number of edges from accept to result capture.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                          input logic f7b0, input logic ob5, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output logic z, output int lat);
        int w;
        @(negedge clk);
        ALUOp = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
        src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk); #1; w++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL run_op in_ready timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL run_op out_valid timeout: out_valid=%0b required 1", out_valid);
        end
        res = result;
        z   = zero;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready: got %0b want 1", in_ready); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset result: got %h want 0", result); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset zero: got %0b want 0", zero); end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic        f7b0;
        logic        ob5;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed_base();
        vec_t        v[10];
        logic [31:0] res;
        logic        z;
        int          lat;
        v[0] = '{2'b10, 3'd0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd7, 32'd12};
        v[1] = '{2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE};
        v[2] = '{2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0};
        v[3] = '{2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0};
        v[4] = '{2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000};
        v[5] = '{2'b10, 3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000};
        v[6] = '{2'b10, 3'd3, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd1};
        v[7] = '{2'b10, 3'd2, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0};
        v[8] = '{2'b11, 3'd6, 1'b1, 1'b0, 1'b1, 32'd3, 32'd4, 32'd7};
        v[9] = '{2'b10, 3'd5, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].op, v[i].f3, v[i].f7b5, v[i].f7b0, v[i].ob5, v[i].a, v[i].b, res, z, lat);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("FAIL directed[%0d] result: got %h want %h", i, res, v[i].exp);
            end
            checks++;
            if (z !== (v[i].exp == 32'd0)) begin
                failures++;
                $display("FAIL directed[%0d] zero: got %0b want %0b", i, z, v[i].exp == 32'd0);
            end
            checks++;
            if (lat != 1) begin
                failures++;
                $display("FAIL directed[%0d] latency: got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_random_base();
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7b5, f7b0, ob5, z;
        logic [31:0] a, b, res, exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            gen_base_op(op, f3, f7b5, f7b0, ob5, a, b);
            exp = ref_alu(op, f3, f7b5, f7b0, ob5, a, b);
            run_op(op, f3, f7b5, f7b0, ob5, a, b, res, z, lat);
            checks++;
            if (res !== exp || z !== (exp == 32'd0) || lat != 1) begin
                failures++;
                $display("FAIL random_base[%0d] op=%0d f3=%0d: got res=%h z=%0b lat=%0d want res=%h z=%0b lat=1",
                         i, op, f3, res, z, lat, exp, exp == 32'd0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7b5, f7b0, ob5;
        logic [31:0] a, b;
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        @(negedge clk);
        out_ready = 1'b1;
        gen_base_op(op, f3, f7b5, f7b0, ob5, a, b);
        ALUOp = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
        src_a = a; src_b = b; in_valid = 1'b1;
        exp_q.push_back(ref_alu(op, f3, f7b5, f7b0, ob5, a, b));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== exp) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got out_valid=%0b in_ready=%0b result=%h want 1 1 %h",
                         i, out_valid, in_ready, result, exp);
            end
            if (i < 8) begin
                gen_base_op(op, f3, f7b5, f7b0, ob5, a, b);
                ALUOp = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
                src_a = a; src_b = b;
                exp_q.push_back(ref_alu(op, f3, f7b5, f7b0, ob5, a, b));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back drain out_valid: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_hold();
        logic [31:0] a, b, exp;
        a = $urandom; b = $urandom;
        exp = a + b;
        @(negedge clk);
        ALUOp = 2'b00; funct3 = 3'd0; funct7b5 = 1'b0; funct7b0 = 1'b0; opb5 = 1'b0;
        src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            scramble();
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp || zero !== (exp == 32'd0)) begin
                failures++;
                $display("FAIL hold[%0d]: got out_valid=%0b in_ready=%0b result=%h want 1 0 %h",
                         i, out_valid, in_ready, result, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold release out_valid: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] res;
        logic        z;
        int          lat;
        // Reset while a result is held in DONE.
        @(negedge clk);
        ALUOp = 2'b00; funct3 = 3'd0; src_a = 32'd9; src_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_done: got out_valid=%0b in_ready=%0b result=%h zero=%0b want 0 1 0 0",
                     out_valid, in_ready, result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef ALU_MEXT_EN
        // Reset in the middle of an iterative divide.
        @(negedge clk);
        ALUOp = 2'b10; funct3 = 3'd4; funct7b5 = 1'b0; funct7b0 = 1'b1; opb5 = 1'b1;
        src_a = 32'd1000; src_b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_calc busy: got in_ready=%0b out_valid=%0b want 0 0", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_calc: got out_valid=%0b in_ready=%0b result=%h want 0 1 0",
                     out_valid, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
`endif
        run_op(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, res, z, lat);
        checks++;
        if (res !== 32'd5 || z !== 1'b0 || lat != 1) begin
            failures++;
            $display("FAIL post_reset add: got res=%h z=%0b lat=%0d want 5 0 1", res, z, lat);
        end
    endtask

`ifdef ALU_MEXT_EN
    task automatic test_mext();
        vec_t        v[10];
        logic [31:0] a, b, res, exp;
        logic [2:0]  f3;
        logic        z;
        int          lat;
        v[0] = '{2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        v[1] = '{2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        v[2] = '{2'b10, 3'd5, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF};
        v[3] = '{2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'd9, 32'd0, 32'd9};
        v[4] = '{2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[5] = '{2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        v[6] = '{2'b10, 3'd1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        v[7] = '{2'b10, 3'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0};
        v[8] = '{2'b10, 3'd3, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[9] = '{2'b10, 3'd2, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].op, v[i].f3, v[i].f7b5, v[i].f7b0, v[i].ob5, v[i].a, v[i].b, res, z, lat);
            checks++;
            if (res !== v[i].exp || z !== (v[i].exp == 32'd0)) begin
                failures++;
                $display("FAIL mext_directed[%0d] f3=%0d: got res=%h z=%0b want res=%h z=%0b",
                         i, v[i].f3, res, z, v[i].exp, v[i].exp == 32'd0);
            end
            checks++;
            if (lat != XLEN + 1) begin
                failures++;
                $display("FAIL mext_directed[%0d] latency: got %0d want %0d", i, lat, XLEN + 1);
            end
        end
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(15));
                3: a = 32'($urandom_range(1000));
                default: ;
            endcase
            exp = ref_m(f3, a, b);
            run_op(2'b10, f3, 1'($urandom), 1'b1, 1'b1, a, b, res, z, lat);
            checks++;
            if (res !== exp || z !== (exp == 32'd0) || lat != XLEN + 1) begin
                failures++;
                $display("FAIL mext_random[%0d] f3=%0d a=%h b=%h: got res=%h z=%0b lat=%0d want res=%h lat=%0d",
                         i, f3, a, b, res, z, lat, exp, XLEN + 1);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed_base();
        test_random_base();
        test_back_to_back();
        test_hold();
`ifdef ALU_MEXT_EN
        test_mext();
`endif
        test_reset_inflight();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
